// File: rtl/ctrl_fetch_decode.sv
// Multi-cycle fetch/decode/sequencing controller feeding the register file.
// One instruction at a time walks FETCH -> DECODE -> EXECUTE -> [MEM] -> WB.
module ctrl_fetch_decode #(
    parameter int PC_WIDTH   = 5,
    parameter int IMEM_DEPTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    output logic [PC_WIDTH-1:0]   IMEM_addr,
    input  logic [DATA_WIDTH-1:0] IMEM_data,
    input  logic [PC_WIDTH-1:0]   BRANCH_target,
    output logic [3:0]            IR_ARn,
    output logic [3:0]            IR_ARs,
    output logic [3:0]            IR_ARm,
    output logic [11:0]           IR_imm,
    output logic [3:0]            mux_ARd_or_15,
    output logic                  CNTRL_write_en_ARd,
    output logic [PC_WIDTH-1:0]   PC_next,
    output logic [2:0]            CNTRL_alu_op,
    output logic                  CNTRL_sel_DMEM,
    output logic                  CNTRL_DMEM_we,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALTED  = 3'd5
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(IMEM_DEPTH - 1);

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;

    logic [3:0]            opcode;
    logic                  op_alu, op_ldr, op_str, op_branch, op_halt;
    logic [PC_WIDTH-1:0]   pc_inc, pc_branch;

    assign opcode    = ir_q[31:28];
    assign op_alu    = ~opcode[3];
    assign op_ldr    = (opcode == 4'h8);
    assign op_str    = (opcode == 4'h9);
    assign op_branch = (opcode == 4'hA);
    assign op_halt   = (opcode == 4'hF);

    // PC wraps inside the ROM; out-of-range branch bits are masked away.
    assign pc_inc    = (pc_q == PC_LAST) ? '0 : pc_q + PC_WIDTH'(1);
    assign pc_branch = BRANCH_target & PC_LAST;

    assign IMEM_addr    = pc_q;
    assign PC_next      = pc_q;
    assign IR_ARn       = ir_q[23:20];
    assign IR_ARs       = ir_q[19:16];
    assign IR_ARm       = ir_q[15:12];
    assign IR_imm       = ir_q[11:0];
    assign CNTRL_alu_op = ir_q[31] ? 3'b000 : ir_q[30:28];
    assign halted       = (state_q == S_HALTED);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        ir_d               = ir_q;
        CNTRL_write_en_ARd = 1'b0;
        CNTRL_DMEM_we      = 1'b0;
        CNTRL_sel_DMEM     = 1'b0;
        mux_ARd_or_15      = ir_q[27:24];

        case (state_q)
            S_FETCH: begin
                ir_d    = IMEM_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = op_halt ? S_HALTED : S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = (op_ldr || op_str) ? S_MEM : S_WB;
            end
            S_MEM: begin
                CNTRL_DMEM_we  = op_str;
                CNTRL_sel_DMEM = op_ldr;
                state_d        = S_WB;
            end
            S_WB: begin
                // NOP opcodes (0xB-0xE) fall through with the write enable low.
                CNTRL_sel_DMEM     = op_ldr;
                CNTRL_write_en_ARd = op_alu || op_ldr || op_branch;
                if (op_branch) begin
                    mux_ARd_or_15 = 4'd15;
                    pc_d          = pc_branch;
                end else begin
                    pc_d = pc_inc;
                end
                state_d = S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_fetch_decode.sv
// Directed bench for ctrl_fetch_decode: a small ROM program is stepped cycle by cycle.
module tb_ctrl_fetch_decode;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b1;
    logic [4:0]  IMEM_addr;
    logic [31:0] IMEM_data;
    logic [4:0]  BRANCH_target = 5'd0;
    logic [3:0]  IR_ARn, IR_ARs, IR_ARm, mux_ARd_or_15;
    logic [11:0] IR_imm;
    logic        CNTRL_write_en_ARd, CNTRL_sel_DMEM, CNTRL_DMEM_we, halted;
    logic [4:0]  PC_next;
    logic [2:0]  CNTRL_alu_op;

    logic [31:0] rom [16];
    int n_cmp = 0;
    int n_err = 0;

    assign IMEM_data = rom[IMEM_addr[3:0]];

    always #5 CLOCK_50 = ~CLOCK_50;

    ctrl_fetch_decode #(.PC_WIDTH(5), .IMEM_DEPTH(16), .DATA_WIDTH(32)) dut (
        .CLOCK_50           (CLOCK_50),
        .RESET_N            (RESET_N),
        .IMEM_addr          (IMEM_addr),
        .IMEM_data          (IMEM_data),
        .BRANCH_target      (BRANCH_target),
        .IR_ARn             (IR_ARn),
        .IR_ARs             (IR_ARs),
        .IR_ARm             (IR_ARm),
        .IR_imm             (IR_imm),
        .mux_ARd_or_15      (mux_ARd_or_15),
        .CNTRL_write_en_ARd (CNTRL_write_en_ARd),
        .PC_next            (PC_next),
        .CNTRL_alu_op       (CNTRL_alu_op),
        .CNTRL_sel_DMEM     (CNTRL_sel_DMEM),
        .CNTRL_DMEM_we      (CNTRL_DMEM_we),
        .halted             (halted)
    );

    task automatic next_cycle;
        @(negedge CLOCK_50);
        #1;
    endtask

    // Leaves the bench sampling the first FETCH cycle after release.
    task automatic apply_reset;
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        #13;
        RESET_N = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) repeat (3) next_cycle();
            n_cmp++;
            if ({IMEM_addr, PC_next} !== 10'd0) begin
                n_err++; $display("FAIL rst_pc%0d got %0d/%0d want 0/0", k, IMEM_addr, PC_next);
            end
            n_cmp++;
            if ({CNTRL_write_en_ARd, CNTRL_DMEM_we, CNTRL_sel_DMEM, halted} !== 4'b0000) begin
                n_err++; $display("FAIL rst_strobes%0d got %b want 0000", k,
                                  {CNTRL_write_en_ARd, CNTRL_DMEM_we, CNTRL_sel_DMEM, halted});
            end
            n_cmp++;
            if ({IR_ARn, IR_ARs, IR_ARm, IR_imm, mux_ARd_or_15, CNTRL_alu_op} !== 35'd0) begin
                n_err++; $display("FAIL rst_fields%0d got %h want 0", k,
                                  {IR_ARn, IR_ARs, IR_ARm, IR_imm, mux_ARd_or_15, CNTRL_alu_op});
            end
        end
    endtask

    task automatic test_alu;
        apply_reset();
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) next_cycle();
            n_cmp++;
            if (CNTRL_write_en_ARd !== (c == 4)) begin
                n_err++; $display("FAIL alu_we_c%0d got %b want %b", c, CNTRL_write_en_ARd, (c == 4));
            end
            n_cmp++;
            if (PC_next !== ((c == 5) ? 5'd1 : 5'd0) || IMEM_addr !== PC_next) begin
                n_err++; $display("FAIL alu_pc_c%0d got %0d/%0d want %0d", c, PC_next, IMEM_addr, (c == 5) ? 1 : 0);
            end
            if (c == 2) begin
                n_cmp++;
                if ({IR_ARn, IR_ARs, IR_ARm, IR_imm} !== 24'h456ABC) begin
                    n_err++; $display("FAIL alu_fields got %h want 456abc", {IR_ARn, IR_ARs, IR_ARm, IR_imm});
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (CNTRL_alu_op !== 3'd1) begin
                    n_err++; $display("FAIL alu_op got %0d want 1", CNTRL_alu_op);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (mux_ARd_or_15 !== 4'd3 || CNTRL_sel_DMEM !== 1'b0) begin
                    n_err++; $display("FAIL alu_wb got ard=%0d sel=%b want ard=3 sel=0", mux_ARd_or_15, CNTRL_sel_DMEM);
                end
            end
        end
    endtask

    task automatic test_ldr;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) next_cycle();
            n_cmp++;
            if (CNTRL_sel_DMEM !== (c == 4 || c == 5)) begin
                n_err++; $display("FAIL ldr_sel_c%0d got %b want %b", c, CNTRL_sel_DMEM, (c == 4 || c == 5));
            end
            n_cmp++;
            if (CNTRL_write_en_ARd !== (c == 5) || CNTRL_DMEM_we !== 1'b0) begin
                n_err++; $display("FAIL ldr_we_c%0d got we=%b dwe=%b want we=%b dwe=0", c,
                                  CNTRL_write_en_ARd, CNTRL_DMEM_we, (c == 5));
            end
            if (c == 5) begin
                n_cmp++;
                if (mux_ARd_or_15 !== 4'd5) begin
                    n_err++; $display("FAIL ldr_ard got %0d want 5", mux_ARd_or_15);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (PC_next !== 5'd2) begin
                    n_err++; $display("FAIL ldr_pc got %0d want 2", PC_next);
                end
            end
        end
    endtask

    task automatic test_str;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) next_cycle();
            n_cmp++;
            if (CNTRL_DMEM_we !== (c == 4)) begin
                n_err++; $display("FAIL str_dwe_c%0d got %b want %b", c, CNTRL_DMEM_we, (c == 4));
            end
            n_cmp++;
            if (CNTRL_write_en_ARd !== 1'b0 || CNTRL_sel_DMEM !== 1'b0) begin
                n_err++; $display("FAIL str_we_c%0d got we=%b sel=%b want 0/0", c, CNTRL_write_en_ARd, CNTRL_sel_DMEM);
            end
            if (c == 6) begin
                n_cmp++;
                if (PC_next !== 5'd3) begin
                    n_err++; $display("FAIL str_pc got %0d want 3", PC_next);
                end
            end
        end
    endtask

    task automatic test_branch;
        BRANCH_target = 5'b0_0111;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) next_cycle();
            n_cmp++;
            if (CNTRL_write_en_ARd !== (c == 4)) begin
                n_err++; $display("FAIL br_we_c%0d got %b want %b", c, CNTRL_write_en_ARd, (c == 4));
            end
            if (c == 2 || c == 4) begin
                n_cmp++;
                if (mux_ARd_or_15 !== ((c == 4) ? 4'd15 : 4'd0)) begin
                    n_err++; $display("FAIL br_ard_c%0d got %0d want %0d", c, mux_ARd_or_15, (c == 4) ? 15 : 0);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (IMEM_addr !== 5'd7) begin
                    n_err++; $display("FAIL br_target got %0d want 7", IMEM_addr);
                end
            end
        end
    endtask

    // Branch 7 -> 14 (bit 4 of the target set), write to R15 at 14, NOP at 15, wrap to 0.
    task automatic test_wrap;
        logic [4:0] exp_pc;
        BRANCH_target = 5'b1_1110;
        for (int i = 0; i < 3; i++) begin
            exp_pc = (i == 0) ? 5'd7 : (i == 1) ? 5'd14 : 5'd15;
            for (int c = 1; c <= 4; c++) begin
                if (!(i == 0 && c == 1)) next_cycle();
                n_cmp++;
                if (PC_next !== exp_pc || PC_next > 5'd15) begin
                    n_err++; $display("FAIL wrap_pc_i%0d_c%0d got %0d want %0d", i, c, PC_next, exp_pc);
                end
                if (c == 4) begin
                    n_cmp++;
                    if (CNTRL_write_en_ARd !== (i != 2) || mux_ARd_or_15 !== 4'd15) begin
                        n_err++; $display("FAIL wrap_wb_i%0d got we=%b ard=%0d want we=%b ard=15", i,
                                          CNTRL_write_en_ARd, mux_ARd_or_15, (i != 2));
                    end
                end
            end
        end
        next_cycle();
        n_cmp++;
        if (IMEM_addr !== 5'd0) begin
            n_err++; $display("FAIL wrap_zero got %0d want 0", IMEM_addr);
        end
    endtask

    // Runs 0..3 again; the branch at 3 now lands on the HALT at 4.
    task automatic test_halt;
        int n = 0;
        BRANCH_target = 5'd4;
        while (!halted && n < 40) begin
            next_cycle();
            n++;
            n_cmp++;
            if (CNTRL_write_en_ARd && CNTRL_DMEM_we) begin
                n_err++; $display("FAIL halt_run_overlap at step %0d got both strobes high", n);
            end
        end
        n_cmp++;
        if (n !== 20) begin
            n_err++; $display("FAIL halt_latency got %0d want 20", n);
        end
        for (int k = 0; k < 25; k++) begin
            next_cycle();
            n_cmp++;
            if (halted !== 1'b1 || PC_next !== 5'd4 ||
                {CNTRL_write_en_ARd, CNTRL_DMEM_we, CNTRL_sel_DMEM} !== 3'b000) begin
                n_err++; $display("FAIL halt_hold_k%0d got h=%b pc=%0d str=%b want h=1 pc=4 str=000", k,
                                  halted, PC_next, {CNTRL_write_en_ARd, CNTRL_DMEM_we, CNTRL_sel_DMEM});
            end
        end
    endtask

    task automatic test_reset_mid;
        rom[0] = 32'h9600_0000;
        apply_reset();
        n_cmp++;
        if (halted !== 1'b0) begin
            n_err++; $display("FAIL mid_halt_clear got %b want 0", halted);
        end
        repeat (3) next_cycle();
        n_cmp++;
        if (CNTRL_DMEM_we !== 1'b1) begin
            n_err++; $display("FAIL mid_mem_dwe got %b want 1", CNTRL_DMEM_we);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        n_cmp++;
        if ({CNTRL_DMEM_we, CNTRL_write_en_ARd, IMEM_addr} !== 7'd0) begin
            n_err++; $display("FAIL mid_async_drop got dwe=%b we=%b addr=%0d want 0/0/0",
                              CNTRL_DMEM_we, CNTRL_write_en_ARd, IMEM_addr);
        end
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        #1;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) next_cycle();
            n_cmp++;
            if (IMEM_addr !== ((c == 6) ? 5'd1 : 5'd0) || CNTRL_DMEM_we !== (c == 4)) begin
                n_err++; $display("FAIL mid_restart_c%0d got addr=%0d dwe=%b want addr=%0d dwe=%b", c,
                                  IMEM_addr, CNTRL_DMEM_we, (c == 6) ? 1 : 0, (c == 4));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'h0000_0000;
        rom[0]  = 32'h1345_6ABC;
        rom[1]  = 32'h8512_3000;
        rom[2]  = 32'h9600_0000;
        rom[3]  = 32'hA000_0000;
        rom[4]  = 32'hF000_0000;
        rom[7]  = 32'hA000_0000;
        rom[14] = 32'h0F00_0000;
        rom[15] = 32'hBF00_0000;

        test_reset();
        test_alu();
        test_ldr();
        test_str();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
